mem_io_bridge: RTL and testbench
================================

# mem_io_bridge

Memory-side bridge directly downstream of the CPU core's memory port. It decodes the core's 24-bit word address into a RAM window and a memory-mapped I/O window. It returns read data with a fixed one-cycle latency, which matches the core's fetch/decode and load timing. The I/O window holds an LED register, synchronized switch inputs, a small character-output FIFO with a valid/ready drain port, and a coherent 32-bit cycle counter.

## Interface
- RAM_AW, 16: RAM word-address width; the RAM window is 0x000000 to 2^RAM_AW-1.
- TX_DEPTH, 4: TX FIFO depth in entries; must be a power of 2, minimum 2.
- clk  in  1  system clock, rising edge
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- core_to_mem_addr  in  24  word address from core
- core_to_mem_data  in  16  write data from core
- core_to_mem_write_enable  in  1  write strobe, single cycle
- mem_to_core_data  out  16  read data to core, valid one cycle after address
- ram_addr  out  RAM_AW  synchronous RAM address
- ram_wdata  out  16  RAM write data
- ram_we  out  1  RAM write enable
- ram_rdata  in  16  RAM read data, one-cycle latency
- switches  in  16  asynchronous board switches
- leds  out  16  LED register
- tx_data  out  8  FIFO head byte
- tx_valid  out  1  FIFO non-empty
- tx_ready  in  1  consumer accepts the head byte when tx_valid && tx_ready

## Operation
- Decode is combinational on core_to_mem_addr:
  - RAM: addr < 2^RAM_AW.
  - IO: addr[23:8] == 0xFF00.
  - Anything else is unmapped.
- RAM path:
  - ram_addr = addr[RAM_AW-1:0] and ram_wdata = core_to_mem_data at all times.
  - ram_we = write_enable && RAM hit.
- IO registers, at word offset addr[7:0]:
  - 0x00 LED: R/W. Reset 0x0000. A write updates leds on the next edge.
  - 0x01 SW: read-only. switches passes through a 2-flop synchronizer; reset 0.
  - 0x02 TX_DATA: write-only. Pushes core_to_mem_data[7:0] into the FIFO. A push while full is dropped and sets the sticky ovf bit. Reads return 0.
  - 0x03 TX_STAT: read returns {8'b0, count[4:0], ovf, empty, full}. Any write clears ovf.
  - 0x04 CYC_LO: read returns cycle[15:0]. The same edge copies cycle[31:16] into the hi_shadow register.
  - 0x05 CYC_HI: read returns hi_shadow. Writes are ignored.
  - Other offsets read 0x0000; writes to them are ignored.
- Unmapped addresses read 0x0000; writes to them are ignored.
- Cycle counter:
  - 32 bits, +1 every clock, wraps from 0xFFFFFFFF to 0. Reset 0.
  - The value sampled is the counter as it stands before the edge that registers the read.
- TX FIFO:
  - Circular buffer with read/write pointers and a count of 0..TX_DEPTH.
  - Pop occurs when tx_valid && tx_ready. Push occurs on a TX_DATA write that is not blocked.
  - A push while full is accepted if a pop happens in the same cycle; count stays at TX_DEPTH and ovf is not set.
  - Simultaneous push and pop at any count leaves count unchanged.
  - tx_data = mem[rd_ptr]; tx_valid = (count != 0).
- Read return:
  - On each edge, a registered source select (RAM/IO/NONE) and a registered IO read value are captured from the current address.
  - mem_to_core_data = ram_rdata if select==RAM, else io_q if select==IO, else 0.
  - Reads have no side effects except the hi_shadow capture.

## Timing
- Address presented in cycle N means data is on mem_to_core_data throughout cycle N+1. Back-to-back reads are supported every cycle.
- Writes take effect at the end of cycle N. A read of the same location in cycle N+1 returns the new value. A write cycle also registers a read select, so returned data for a write cycle is don't-care.
- Reset, asynchronous assert:
  - leds=0, tx_valid=0, FIFO empty, ovf=0, counter=0, hi_shadow=0, synchronizer=0.
  - Select=NONE, so mem_to_core_data=0.
  - ram_we follows its inputs combinationally; the core holds write_enable low in reset.
- Reset asserted mid-drain: the FIFO contents are discarded and tx_valid drops immediately. Release is synchronous to the first edge after rst_n rises.
- Switch change to SW read value: 2 cycles synchronization, plus 1 cycle read latency.

## Test plan
- Reset, then read 0xFF0000, 0xFF0003, 0x123456: returns 0x0000, 0x0002 (empty), 0x0000. tx_valid=0, leds=0.
- Write 0xBEEF to RAM 0x004000, then read 0x004000 the next cycle: ram_we pulses once, mem_to_core_data=0xBEEF one cycle after the read address.
- tx_ready=0; write 0x41,0x42,0x43,0x44,0x45 to 0xFF0002: TX_STAT reads 0x0025 (count 4, ovf, full). Raise tx_ready: bytes 0x41..0x44 drain on consecutive cycles, then tx_valid=0. Write 0xFF0003: ovf clears, TX_STAT reads 0x0002.
- FIFO full with tx_ready=1, push 0x55 in the same cycle as the pop: count stays 4, ovf=0, and 0x55 appears as the last byte drained.
- Preload counter to 0x0000FFFF via force/reset timing, read CYC_LO then CYC_HI: the pair is coherent, with no torn value across the 16-bit carry. Counter wraps 0xFFFFFFFF to 0.
- switches=0xA5A5: SW read issued 2 cycles later returns 0xA5A5. Write LED 0x00FF: leds=0x00FF the next cycle. Assert rst_n low mid-drain: tx_valid=0 immediately.

Source files
------------

// File: rtl/mem_io_bridge.sv
// Memory-side bridge for the core: decodes RAM and memory-mapped I/O windows and returns read
// data one cycle after the address. I/O holds LEDs, switches, a TX byte FIFO and a cycle counter.
module mem_io_bridge #(
  parameter int unsigned RAM_AW   = 16,
  parameter int unsigned TX_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [23:0]       core_to_mem_addr,
  input  logic [15:0]       core_to_mem_data,
  input  logic              core_to_mem_write_enable,
  output logic [15:0]       mem_to_core_data,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [15:0]       ram_wdata,
  output logic              ram_we,
  input  logic [15:0]       ram_rdata,
  input  logic [15:0]       switches,
  output logic [15:0]       leds,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready
);

  localparam int unsigned PW = (TX_DEPTH > 1) ? $clog2(TX_DEPTH) : 1;
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {SelNone, SelRam, SelIo} sel_e;

  localparam logic [7:0] OffLed    = 8'h00;
  localparam logic [7:0] OffSw     = 8'h01;
  localparam logic [7:0] OffTxData = 8'h02;
  localparam logic [7:0] OffTxStat = 8'h03;
  localparam logic [7:0] OffCycLo  = 8'h04;
  localparam logic [7:0] OffCycHi  = 8'h05;

  sel_e             sel_q, sel_d;
  logic [15:0]      io_q, io_d;
  logic [15:0]      leds_q;
  logic [15:0]      sw_meta_q, sw_sync_q;
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             ovf_q, ovf_d;
  logic [31:0]      cyc_q;
  logic [15:0]      hi_q;
  logic [7:0]       tx_mem [TX_DEPTH];

  logic             hit_ram, hit_io;
  logic [7:0]       offset;
  logic             io_wr;
  logic             push_req, push, pop;
  logic             fifo_full, fifo_empty;

  assign offset  = core_to_mem_addr[7:0];
  assign hit_ram = (32'(core_to_mem_addr) >> RAM_AW) == 32'd0;
  assign hit_io  = core_to_mem_addr[23:8] == 16'hFF00;
  assign io_wr   = core_to_mem_write_enable && hit_io;

  assign ram_addr  = core_to_mem_addr[RAM_AW-1:0];
  assign ram_wdata = core_to_mem_data;
  assign ram_we    = core_to_mem_write_enable && hit_ram;

  assign fifo_full  = count_q == CW'(TX_DEPTH);
  assign fifo_empty = count_q == '0;
  assign tx_valid   = !fifo_empty;
  assign tx_data    = tx_mem[rd_ptr_q];
  assign leds       = leds_q;

  // A push into a full FIFO still lands when the head leaves in the same cycle.
  assign pop      = tx_valid && tx_ready;
  assign push_req = io_wr && (offset == OffTxData);
  assign push     = push_req && (!fifo_full || pop);

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    ovf_d = ovf_q;
    if (io_wr && (offset == OffTxStat)) begin
      ovf_d = 1'b0;
    end else if (push_req && !push) begin
      ovf_d = 1'b1;
    end
  end

  always_comb begin
    io_d = 16'h0000;
    case (offset)
      OffLed:    io_d = leds_q;
      OffSw:     io_d = sw_sync_q;
      OffTxStat: io_d = {8'h00, 5'(count_q), ovf_q, fifo_empty, fifo_full};
      OffCycLo:  io_d = cyc_q[15:0];
      OffCycHi:  io_d = hi_q;
      default:   io_d = 16'h0000;
    endcase
  end

  always_comb begin
    sel_d = SelNone;
    if (hit_ram) begin
      sel_d = SelRam;
    end else if (hit_io) begin
      sel_d = SelIo;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q     <= SelNone;
      io_q      <= '0;
      leds_q    <= '0;
      sw_meta_q <= '0;
      sw_sync_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      cyc_q     <= '0;
      hi_q      <= '0;
    end else begin
      sel_q     <= sel_d;
      io_q      <= io_d;
      sw_meta_q <= switches;
      sw_sync_q <= sw_meta_q;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      cyc_q     <= cyc_q + 32'd1;
      if (io_wr && (offset == OffLed)) begin
        leds_q <= core_to_mem_data;
      end
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      // Latching the high half with the low-half read keeps the 32-bit pair coherent.
      if (hit_io && (offset == OffCycLo)) begin
        hi_q <= cyc_q[31:16];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      tx_mem[wr_ptr_q] <= core_to_mem_data[7:0];
    end
  end

  always_comb begin
    mem_to_core_data = 16'h0000;
    unique case (sel_q)
      SelRam:  mem_to_core_data = ram_rdata;
      SelIo:   mem_to_core_data = io_q;
      default: mem_to_core_data = 16'h0000;
    endcase
  end

endmodule

// File: tb/tb_mem_io_bridge.sv
// Self-checking bench for mem_io_bridge: directed scenarios plus a randomized phase, all checked
// against a transaction-level model of the memory map, FIFO queue and cycle count.
module tb_mem_io_bridge;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [23:0] core_to_mem_addr = 24'h800000;
  logic [15:0] core_to_mem_data = '0;
  logic        core_to_mem_write_enable = 1'b0;
  logic [15:0] mem_to_core_data;
  logic [15:0] ram_addr;
  logic [15:0] ram_wdata;
  logic        ram_we;
  logic [15:0] ram_rdata = '0;
  logic [15:0] switches = '0;
  logic [15:0] leds;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;

  always #5 clk = ~clk;

  mem_io_bridge #(.RAM_AW(16), .TX_DEPTH(4)) dut (
    .clk                      (clk),
    .rst_n                    (rst_n),
    .core_to_mem_addr         (core_to_mem_addr),
    .core_to_mem_data         (core_to_mem_data),
    .core_to_mem_write_enable (core_to_mem_write_enable),
    .mem_to_core_data         (mem_to_core_data),
    .ram_addr                 (ram_addr),
    .ram_wdata                (ram_wdata),
    .ram_we                   (ram_we),
    .ram_rdata                (ram_rdata),
    .switches                 (switches),
    .leds                     (leds),
    .tx_data                  (tx_data),
    .tx_valid                 (tx_valid),
    .tx_ready                 (tx_ready)
  );

  // External synchronous RAM device.
  logic [15:0] dev_ram [0:65535];
  always @(posedge clk) begin
    if (ram_we) dev_ram[ram_addr] <= ram_wdata;
    ram_rdata <= dev_ram[ram_addr];
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model state.
  logic [15:0] ref_ram [0:65535];
  logic [15:0] ref_leds;
  logic [7:0]  ref_q[$];
  bit          ref_ovf;
  logic [31:0] ref_cyc;
  logic [15:0] ref_hi;
  logic [15:0] sw_h1, sw_h2;  // switches as driven one and two cycles back
  logic [15:0] sw_val = '0;
  bit          pend_chk = 0;
  logic [15:0] pend_exp;
  string       pend_tag;

  localparam logic [23:0] Idle = 24'h800000;

  function automatic logic [15:0] ref_stat();
    int n = ref_q.size();
    return {8'h00, 5'(n), ref_ovf, (n == 0), (n == 4)};
  endfunction

  // One bus cycle: drive on the falling edge, the next rising edge registers it.
  task automatic op(input logic [23:0] a, input logic [15:0] d, input bit we, input bit rdy,
                    input bit chk, input string tag);
    logic [15:0] exp;
    bit          is_ram, is_io, popped, was_full;
    logic [7:0]  off;
    @(negedge clk);
    if (pend_chk) check(pend_tag, 32'(mem_to_core_data), 32'(pend_exp));
    if (chk) begin
      check("leds", 32'(leds), 32'(ref_leds));
      check("tx_valid", 32'(tx_valid), 32'(ref_q.size() != 0));
      if (ref_q.size() != 0) check("tx_data", 32'(tx_data), 32'(ref_q[0]));
    end
    core_to_mem_addr = a;
    core_to_mem_data = d;
    core_to_mem_write_enable = we;
    tx_ready = rdy;
    switches = sw_val;
    is_ram = a < 24'h010000;
    is_io  = a[23:8] == 16'hFF00;
    off    = a[7:0];
    exp    = 16'h0000;
    if (is_ram) exp = ref_ram[a[15:0]];
    else if (is_io) begin
      case (off)
        8'h00: exp = ref_leds;
        8'h01: exp = sw_h2;
        8'h03: exp = ref_stat();
        8'h04: exp = ref_cyc[15:0];
        8'h05: exp = ref_hi;
        default: exp = 16'h0000;
      endcase
    end
    #1;
    if (chk) check("ram_we", 32'(ram_we), 32'(we && is_ram));
    popped   = rdy && (ref_q.size() != 0);
    was_full = ref_q.size() == 4;
    if (we && is_ram) ref_ram[a[15:0]] = d;
    if (popped) void'(ref_q.pop_front());
    if (we && is_io) begin
      case (off)
        8'h00: ref_leds = d;
        8'h02: if (!was_full || popped) ref_q.push_back(d[7:0]); else ref_ovf = 1;
        8'h03: ref_ovf = 0;
        default: ;
      endcase
    end
    if (is_io && off == 8'h04) ref_hi = ref_cyc[31:16];
    ref_cyc = ref_cyc + 32'd1;
    sw_h2 = sw_h1;
    sw_h1 = sw_val;
    pend_chk = chk && !we;
    pend_exp = exp;
    pend_tag = tag;
  endtask

  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    core_to_mem_addr = Idle;
    core_to_mem_write_enable = 1'b0;
    tx_ready = 1'b0;
    #1;
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_rdata", 32'(mem_to_core_data), 32'd0);
    check("rst_leds", 32'(leds), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    // The first edge after release counts as one idle cycle.
    ref_leds = '0;
    ref_q.delete();
    ref_ovf  = 0;
    ref_cyc  = 32'd1;
    ref_hi   = '0;
    sw_h2    = '0;
    sw_h1    = switches;
    pend_chk = 0;
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) begin
      dev_ram[i] = '0;
      ref_ram[i] = '0;
    end
    do_reset();

    op(24'hFF0000, 0, 0, 0, 1, "rd_led_rst");
    op(24'hFF0003, 0, 0, 0, 1, "rd_stat_rst");
    op(24'h123456, 0, 0, 0, 1, "rd_unmapped");
    op(Idle, 0, 0, 0, 1, "idle");

    op(24'h004000, 16'hBEEF, 1, 0, 1, "wr_ram");
    op(24'h004000, 0, 0, 0, 1, "rd_ram");
    op(Idle, 0, 0, 0, 1, "idle");

    for (int b = 8'h41; b <= 8'h45; b++) op(24'hFF0002, 16'(b), 1, 0, 1, "push");
    op(24'hFF0003, 0, 0, 0, 1, "stat_ovf_full");
    for (int i = 0; i < 5; i++) op(Idle, 0, 0, 1, 1, "drain");
    op(24'hFF0003, 16'h1234, 1, 0, 1, "clr_ovf");
    op(24'hFF0003, 0, 0, 0, 1, "stat_cleared");
    op(Idle, 0, 0, 0, 1, "idle");

    for (int b = 8'h51; b <= 8'h54; b++) op(24'hFF0002, 16'(b), 1, 0, 1, "push_fill");
    op(24'hFF0002, 16'h0055, 1, 1, 1, "push_pop_full");
    op(24'hFF0003, 0, 0, 0, 1, "stat_after_pp");
    for (int i = 0; i < 5; i++) op(Idle, 0, 0, 1, 1, "drain_pp");

    while (ref_cyc != 32'h0000FFFF) op(Idle, 0, 0, 0, 0, "wait");
    op(24'hFF0004, 0, 0, 0, 1, "cyc_lo_carry");
    op(24'hFF0005, 0, 0, 0, 1, "cyc_hi_carry");
    op(24'hFF0004, 0, 0, 0, 1, "cyc_lo");
    op(24'hFF0005, 16'hFFFF, 1, 0, 1, "cyc_hi_wr");
    op(24'hFF0005, 0, 0, 0, 1, "cyc_hi");

    sw_val = 16'hA5A5;
    op(Idle, 0, 0, 0, 1, "sw_set");
    op(Idle, 0, 0, 0, 1, "idle");
    op(24'hFF0001, 0, 0, 0, 1, "rd_sw");
    op(24'hFF0000, 16'h00FF, 1, 0, 1, "wr_led");
    op(24'hFF0000, 0, 0, 0, 1, "rd_led");
    op(24'hFF0007, 16'hDEAD, 1, 0, 1, "wr_unused");
    op(24'hFF0007, 0, 0, 0, 1, "rd_unused");
    op(24'hFF0100, 16'hDEAD, 1, 0, 1, "wr_unmapped");
    op(24'hFF0000, 0, 0, 0, 1, "rd_led_kept");

    for (int n = 0; n < 400; n++) begin
      logic [23:0] a;
      case ($urandom_range(0, 3))
        0:       a = {8'h00, 12'h2A0, 4'($urandom_range(0, 15))};
        1, 2:    a = {16'hFF00, 8'($urandom_range(0, 7))};
        default: a = ($urandom_range(0, 1) == 1) ? 24'hFF0100 + 24'($urandom_range(0, 7))
                                                 : 24'h010000 + 24'($urandom_range(0, 255));
      endcase
      if ($urandom_range(0, 15) == 0) sw_val = 16'($urandom);
      op(a, 16'($urandom), $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1, 1, "rand");
    end
    op(Idle, 0, 0, 0, 1, "idle");

    while (ref_q.size() != 0) op(Idle, 0, 0, 1, 0, "flush");
    for (int b = 8'h61; b <= 8'h64; b++) op(24'hFF0002, 16'(b), 1, 0, 1, "push_rst");
    op(Idle, 0, 0, 1, 1, "drain_rst");
    op(Idle, 0, 0, 1, 1, "drain_rst");
    do_reset();
    op(24'hFF0003, 0, 0, 0, 1, "stat_post_rst");
    op(24'hFF0000, 0, 0, 0, 1, "led_post_rst");
    op(Idle, 0, 0, 0, 1, "idle");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
